mux_rr_arb: RTL and testbench
=============================

Name: mux_rr_arb

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output and valid/ready handshakes on every input and on the output.
- Successor to the fixed 4:1 case-statement mux.
- Two select modes: fixed (external select, classic mux) and round-robin (internal fair arbitration among valid channels).
- Sits between multiple producers and one consumer in the datapath.

Parameters:
NUM_CH, 4, number of input channels (>=2)
DATA_W, 2, data width per channel
SEL_W, $clog2(NUM_CH), select/channel-id width (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel select used when mode=0
in_data  input  NUM_CH*DATA_W  packed channel data, channel i at [i*DATA_W +: DATA_W]
in_valid  input  NUM_CH  per-channel valid
in_ready  output  NUM_CH  per-channel ready (one-hot or zero)
out_data  output  DATA_W  registered selected data
out_valid  output  1  out_data holds a transfer
out_ready  input  1  consumer accepts
out_ch  output  SEL_W  id of channel that produced out_data

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_ch=0, rr pointer=0. in_ready is combinational and 0 while rst=1. Reset mid-transfer discards the held word; no handshake completes in the reset cycle.
- Output register is a single entry. can_load = !out_valid || out_ready.
- Grant (combinational):
  - mode=0: cand = sel.
  - mode=1: cand = first i with in_valid[i]=1, searching ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1 (wrap modulo NUM_CH).
  - in_ready[cand] = can_load; all other bits 0. in_ready does not depend on in_valid[cand] in mode 0. In mode 1 it is all-zero if no channel is valid.
  - sel >= NUM_CH (non-power-of-2 NUM_CH) in mode 0: no channel granted, in_ready=0.
- Transfer in: in_valid[cand] && in_ready[cand]. Next edge: out_data <= channel data, out_ch <= cand, out_valid <= 1. Latency: 1 clk from accept to out_valid.
- Transfer out: out_valid && out_ready. If no new transfer in the same cycle, out_valid <= 0. A simultaneous out and in gives back-to-back full throughput, one word per clk.
- Stall: out_valid && !out_ready. out_data and out_ch are held stable and in_ready=0.
- Round-robin pointer: updates only on a transfer in with mode=1, ptr <= (cand+1) mod NUM_CH. Unchanged in mode 0.
- Mode change: may occur any cycle. It takes effect on the combinational grant in the same cycle. A held output word is unaffected.
- No channel starves in mode 1: a continuously valid channel is granted within NUM_CH accepts.

Optional Feature:
- Macro: MUX_RR_ARB_XFER_CNT_EN.
- Defined: adds output xfer_cnt [15:0], a count of completed output transfers. It increments on out_valid&&out_ready, saturates at 16'hFFFF, and resets to 0 on rst.
- Undefined: port and counter absent; the rest of the behaviour is identical.

Decomposition:
- Package mux_pkg holds:
  - localparam function for SEL_W (clog2).
  - Mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - Counter width constant XFER_CNT_W=16.
- One sub-module, rr_pick:
  - Purely combinational rotating-priority encoder.
  - Inputs: req[NUM_CH], ptr[SEL_W]. Outputs: gnt_id[SEL_W], gnt_any.
  - Instantiated once for mode 1.

Test Plan (NUM_CH=4, DATA_W=2, ch0..3 data = 11,10,01,00):
1. Fixed mode sweep: mode=0, all valid, out_ready=1, sel=0,1,2,3 each for one clk -> out_data 11,10,01,00 one clk later, out_ch 0..3, in_ready one-hot at sel.
2. Round-robin fairness: mode=1, all in_valid=1, out_ready=1 for 8 clks -> out_ch sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1 after the first clk.
3. Sparse requests: mode=1, only ch1 and ch3 valid -> out_ch alternates 1,3,1,3; in_ready[0] and in_ready[2] stay 0.
4. Backpressure: out_valid=1 holding 10, out_ready=0 for 5 clks -> out_data=10 stable, in_ready=0; release -> next word accepted the same cycle with no loss or duplication.
5. Reset mid-operation: assert rst for 1 clk while out_valid=1 -> out_valid=0, out_data=00, out_ch=0 next clk; the first round-robin grant after reset goes to ch0.
6. With MUX_RR_ARB_XFER_CNT_EN: 10 completed transfers -> xfer_cnt=10; force the count to 16'hFFFE, then 3 more -> 16'hFFFF and held there.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and helpers for the mux_rr_arb block.
//   sel_w_f    - channel-id width for a given channel count
//   MODE_FIXED - external select drives the grant
//   MODE_RR    - rotating-priority arbitration among valid channels
//   XFER_CNT_W - width of the optional output-transfer counter
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   XFER_CNT_W = 16;

  function automatic int sel_w_f(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_arb_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
// Searches req starting at index ptr, wrapping modulo NUM_CH, and reports the
// first requesting channel.
//   req     [NUM_CH]  per-channel request
//   ptr     [SEL_W]   highest-priority index this cycle (must be < NUM_CH)
//   gnt_id  [SEL_W]   winning channel id (0 when nothing requests)
//   gnt_any           at least one request present
module rr_pick
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = sel_w_f(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt_id,
  output logic              gnt_any
);

  // One spare bit so ptr+k cannot overflow before the modulo fold.
  logic [SEL_W:0] idx;

  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, ptr} + (SEL_W+1)'(k);
      if (idx >= (SEL_W+1)'(NUM_CH)) idx = idx - (SEL_W+1)'(NUM_CH);
      if (!gnt_any && req[idx[SEL_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-channel, W-bit multiplexer with a single-entry registered
// output and valid/ready handshakes. mode=0 selects the channel given by sel;
// mode=1 arbitrates round-robin among valid channels.
//   clk, rst            rising-edge clock, synchronous active-high reset
//   mode, sel           grant mode and fixed-mode channel select
//   in_data/valid/ready per-channel producer handshake (in_ready one-hot or 0)
//   out_data/valid/ready consumer handshake, out_ch = source channel id
//   xfer_cnt            saturating count of output transfers, present only
//                       when MUX_RR_ARB_XFER_CNT_EN is defined
module mux_rr_arb
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 2,
  localparam int SEL_W  = sel_w_f(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_ch
`ifdef MUX_RR_ARB_XFER_CNT_EN
  ,
  output logic [XFER_CNT_W-1:0]    xfer_cnt
`endif
);

  logic              can_load;
  logic              cand_ok;
  logic              xfer_in;
  logic [SEL_W-1:0]  cand;
  logic [SEL_W-1:0]  ptr_next;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_gnt_id;
  logic              rr_gnt_any;
  logic [DATA_W-1:0] cand_data;

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_id  (rr_gnt_id),
    .gnt_any (rr_gnt_any)
  );

  always_comb begin
    can_load = !out_valid || out_ready;
    if (mode == MODE_RR) begin
      cand    = rr_gnt_id;
      cand_ok = rr_gnt_any;
    end else begin
      cand    = sel;
      // sel can exceed the channel count when NUM_CH is not a power of two.
      cand_ok = ({1'b0, sel} < (SEL_W+1)'(NUM_CH));
    end
    in_ready  = '0;
    cand_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (SEL_W'(i) == cand) begin
        cand_data = in_data[i*DATA_W +: DATA_W];
        if (cand_ok && can_load && !rst) in_ready[i] = 1'b1;
      end
    end
    xfer_in  = |(in_valid & in_ready);
    ptr_next = (cand == SEL_W'(NUM_CH-1)) ? '0 : cand + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer_in) begin
        out_valid <= 1'b1;
        out_data  <= cand_data;
        out_ch    <= cand;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer_in && mode == MODE_RR) rr_ptr <= ptr_next;
    end
  end

`ifdef MUX_RR_ARB_XFER_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready && xfer_cnt != '1) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_arb.sv
module tb_mux_rr_arb;

  localparam int N = 4;
  localparam int W = 2;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_ch;
`ifdef MUX_RR_ARB_XFER_CNT_EN
  logic [15:0]     xfer_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit       m_on = 0;
  bit       m_valid;
  int       m_data;
  int       m_ch;
  int       m_ptr;

  // ch0..3 = 11,10,01,00
  localparam logic [N*W-1:0] PLAN_DATA = 8'b00_01_10_11;

  mux_rr_arb #(.NUM_CH(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
`ifdef MUX_RR_ARB_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int ch_data(input logic [N*W-1:0] d, input int c);
    return int'((d >> (c * W)) & ((1 << W) - 1));
  endfunction

  // Which channel the spec rules grant right now (-1 = none), from model state.
  function automatic int model_cand();
    if (!mode) return (int'(sel) < N) ? int'(sel) : -1;
    for (int k = 0; k < N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int c;
    c = model_cand();
    if (rst || c < 0 || !(!m_valid || out_ready)) return '0;
    return N'(1) << c;
  endfunction

  task automatic model_update();
    int c;
    bit acc;
    if (rst) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
      return;
    end
    c   = model_cand();
    acc = (c >= 0) && (!m_valid || out_ready) && in_valid[c];
    if (acc) begin
      m_valid = 1; m_data = ch_data(in_data, c); m_ch = c;
      if (mode) m_ptr = (c + 1) % N;
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_on) model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    mode = 0; sel = 0; in_data = PLAN_DATA; in_valid = '0; out_ready = 0;
    do_reset();
    n_tests++;
    if ({out_valid, out_data, out_ch} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%b ch=%0d want all zero", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_fixed_sweep();
    logic [W-1:0] exp_d [N] = '{2'b11, 2'b10, 2'b01, 2'b00};
    do_reset();
    mode = 0; in_valid = '1; out_ready = 1;
    for (int s = 0; s < N; s++) begin
      sel = SW'(s);
      #1;
      n_tests++;
      if (in_ready !== N'(1 << s)) begin
        n_fail++;
        $display("FAIL fixed_ready sel=%0d: got %b want %b", s, in_ready, N'(1 << s));
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp_d[s] || out_ch !== SW'(s)) begin
        n_fail++;
        $display("FAIL fixed_out sel=%0d: got v=%b d=%b ch=%0d want v=1 d=%b ch=%0d",
                 s, out_valid, out_data, out_ch, exp_d[s], s);
      end
    end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    mode = 1; in_valid = '1; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_tests++;
      if (in_ready !== N'(1 << (i % N))) begin
        n_fail++;
        $display("FAIL rr_ready step %0d: got %b want %b", i, in_ready, N'(1 << (i % N)));
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== SW'(i % N)) begin
        n_fail++;
        $display("FAIL rr_seq step %0d: got v=%b ch=%0d want v=1 ch=%0d", i, out_valid, out_ch, i % N);
      end
    end
  endtask

  task automatic test_sparse();
    int exp_ch [4] = '{1, 3, 1, 3};
    do_reset();
    mode = 1; in_valid = 4'b1010; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (in_ready[0] !== 1'b0 || in_ready[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL sparse_idle_ready step %0d: got %b want bits 0,2 low", i, in_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== SW'(exp_ch[i])) begin
        n_fail++;
        $display("FAIL sparse_seq step %0d: got ch=%0d want %0d", i, out_ch, exp_ch[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 0; sel = 1; in_valid = '1; out_ready = 1;
    tick();
    out_ready = 0; sel = 2;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (in_ready !== '0) begin
        n_fail++;
        $display("FAIL stall_ready cycle %0d: got %b want 0000", i, in_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 2'b10 || out_ch !== 2'd1) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: got v=%b d=%b ch=%0d want v=1 d=10 ch=1",
                 i, out_valid, out_data, out_ch);
      end
    end
    out_ready = 1;
    #1;
    n_tests++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL release_ready: got %b want 0100", in_ready);
    end
    tick();
    in_valid = '0;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 2'b01 || out_ch !== 2'd2) begin
      n_fail++;
      $display("FAIL release_word: got v=%b d=%b ch=%0d want v=1 d=01 ch=2", out_valid, out_data, out_ch);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_drain: got v=%b want 0 (duplicate word)", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1; in_valid = '1; out_ready = 1;
    tick(); tick();
    rst = 1;
    #1;
    n_tests++;
    if (in_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 0000", in_ready);
    end
    tick();
    rst = 0;
    n_tests++;
    if ({out_valid, out_data, out_ch} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b d=%b ch=%0d want all zero", out_valid, out_data, out_ch);
    end
    #1;
    n_tests++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b want 0001", in_ready);
    end
    tick();
    n_tests++;
    if (out_ch !== 2'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_ch: got ch=%0d v=%b want ch=0 v=1", out_ch, out_valid);
    end
  endtask

  task automatic test_random();
    rst = 1; m_on = 1; tick(); rst = 0;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, N - 1));
      in_data   = N*W'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_tests++;
      if (in_ready !== model_ready()) begin
        n_fail++;
        $display("FAIL rand_ready cycle %0d: got %b want %b", i, in_ready, model_ready());
      end
      tick();
      n_tests++;
      if (out_valid !== m_valid || (m_valid &&
          (out_data !== W'(m_data) || out_ch !== SW'(m_ch)))) begin
        n_fail++;
        $display("FAIL rand_out cycle %0d: got v=%b d=%b ch=%0d want v=%b d=%0d ch=%0d",
                 i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
      end
    end
    rst = 0; m_on = 0;
  endtask

`ifdef MUX_RR_ARB_XFER_CNT_EN
  task automatic test_xfer_cnt();
    in_data = PLAN_DATA;
    do_reset();
    mode = 1; in_valid = '1; out_ready = 1;
    for (int i = 0; i < 11; i++) tick();
    n_tests++;
    if (xfer_cnt !== 16'd10) begin
      n_fail++;
      $display("FAIL xfer_cnt_10: got %0d want 10", xfer_cnt);
    end
    out_ready = 0; in_valid = '0;
    tick();
    force dut.xfer_cnt = 16'hFFFE;
    tick();
    release dut.xfer_cnt;
    out_ready = 1; in_valid = '1;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (xfer_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL xfer_cnt_sat: got %h want ffff", xfer_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1; mode = 0; sel = 0; in_data = PLAN_DATA; in_valid = '0; out_ready = 0;
    @(negedge clk);
    test_reset();
    test_fixed_sweep();
    test_rr_fairness();
    test_sparse();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef MUX_RR_ARB_XFER_CNT_EN
    test_xfer_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
